// File: rtl/avmm_seven_segment_array_if.sv
`default_nettype none
// ============================================================================
// Module   : avmm_seven_segment_array_if
// Brief    : Avalon-MM slave bus bundle for the seven-segment array block.
// Revision : 1.0
// ============================================================================
interface avmm_seven_segment_array_if;
    logic [3:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata, avs_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/avmm_seven_segment_array.sv
`default_nettype none
// ============================================================================
// Module   : avmm_seven_segment_array
// Brief    : Avalon-MM register block driving NUM_DIGITS active-low 7-segment
//            digits with hex decode, raw override, blank/blink and PWM dimming.
// Revision : 1.0
// ============================================================================
module avmm_seven_segment_array #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int PWM_BITS   = 4
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    avmm_seven_segment_array_if.slave      avs,
    output logic [7*NUM_DIGITS-1:0]        seg_n
);
    localparam int                  c_cnt_w      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last   = c_cnt_w'(BLINK_DIV - 1);
    localparam logic [3:0]          c_addr_value = 4'd0;
    localparam logic [3:0]          c_addr_ctrl  = 4'd1;
    localparam logic [3:0]          c_addr_blank = 4'd2;
    localparam logic [3:0]          c_addr_blink = 4'd3;
    localparam logic [3:0]          c_addr_rawen = 4'd4;
    localparam logic [3:0]          c_addr_stat  = 4'd5;

    logic [4*NUM_DIGITS-1:0]      value_q,   value_d;
    logic                         enable_q,  enable_d;
    logic [PWM_BITS-1:0]          bright_q,  bright_d;
    logic [NUM_DIGITS-1:0]        blank_q,   blank_d;
    logic [NUM_DIGITS-1:0]        blink_q,   blink_d;
    logic [NUM_DIGITS-1:0]        rawen_q,   rawen_d;
    logic [NUM_DIGITS-1:0][6:0]   raw_q,     raw_d;
    logic [c_cnt_w-1:0]           cnt_q,     cnt_d;
    logic                         phase_q,   phase_d;
    logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
    logic [7*NUM_DIGITS-1:0]      seg_n_q,   seg_n_d;
    logic [31:0]                  rdata_q,   rdata_d;
    logic                         rvalid_q,  rvalid_d;
    logic                         w_lit;
    logic                         w_unused_wdata;

    function automatic logic [6:0] hexdec(input logic [3:0] nib);
        case (nib)
            4'h0: hexdec = 7'h3F;  4'h1: hexdec = 7'h06;
            4'h2: hexdec = 7'h5B;  4'h3: hexdec = 7'h4F;
            4'h4: hexdec = 7'h66;  4'h5: hexdec = 7'h6D;
            4'h6: hexdec = 7'h7D;  4'h7: hexdec = 7'h07;
            4'h8: hexdec = 7'h7F;  4'h9: hexdec = 7'h6F;
            4'hA: hexdec = 7'h77;  4'hB: hexdec = 7'h7C;
            4'hC: hexdec = 7'h39;  4'hD: hexdec = 7'h5E;
            4'hE: hexdec = 7'h79;  default: hexdec = 7'h71;
        endcase
    endfunction

    // Register writes and free-running counters; a BLINK write restarts the blink phase.
    always_comb begin
        value_d   = value_q;
        enable_d  = enable_q;
        bright_d  = bright_q;
        blank_d   = blank_q;
        blink_d   = blink_q;
        rawen_d   = rawen_q;
        raw_d     = raw_q;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        phase_d   = phase_q;
        if (cnt_q == c_cnt_last) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
        if (avs.avs_write) begin
            case (avs.avs_address)
                c_addr_value: value_d = avs.avs_writedata[4*NUM_DIGITS-1:0];
                c_addr_ctrl: begin
                    enable_d = avs.avs_writedata[0];
                    bright_d = avs.avs_writedata[8 +: PWM_BITS];
                end
                c_addr_blank: blank_d = avs.avs_writedata[NUM_DIGITS-1:0];
                c_addr_blink: begin
                    blink_d = avs.avs_writedata[NUM_DIGITS-1:0];
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
                c_addr_rawen: rawen_d = avs.avs_writedata[NUM_DIGITS-1:0];
                default: begin
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        if (avs.avs_address == 4'(8 + d)) begin
                            raw_d[d] = avs.avs_writedata[6:0];
                        end
                    end
                end
            endcase
        end
    end

    // Read mux samples the pre-edge register state.
    always_comb begin
        rvalid_d = avs.avs_read;
        rdata_d  = rdata_q;
        if (avs.avs_read) begin
            rdata_d = '0;
            case (avs.avs_address)
                c_addr_value: rdata_d[4*NUM_DIGITS-1:0] = value_q;
                c_addr_ctrl: begin
                    rdata_d[0]            = enable_q;
                    rdata_d[8 +: PWM_BITS] = bright_q;
                end
                c_addr_blank: rdata_d[NUM_DIGITS-1:0] = blank_q;
                c_addr_blink: rdata_d[NUM_DIGITS-1:0] = blink_q;
                c_addr_rawen: rdata_d[NUM_DIGITS-1:0] = rawen_q;
                c_addr_stat: begin
                    rdata_d[0]    = phase_q;
                    rdata_d[15:8] = 8'(NUM_DIGITS);
                end
                default: begin
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        if (avs.avs_address == 4'(8 + d)) begin
                            rdata_d[6:0] = raw_q[d];
                        end
                    end
                end
            endcase
        end
    end

    assign w_lit = (bright_q == '1) | (pwm_cnt_q < bright_q);

    always_comb begin
        seg_n_d = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (enable_q & w_lit & ~blank_q[d] & ~(blink_q[d] & phase_q)) begin
                seg_n_d[7*d +: 7] = rawen_q[d] ? ~raw_q[d] : ~hexdec(value_q[4*d +: 4]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q   <= '0;
            enable_q  <= 1'b1;
            bright_q  <= '1;
            blank_q   <= '0;
            blink_q   <= '0;
            rawen_q   <= '0;
            raw_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            pwm_cnt_q <= '0;
            seg_n_q   <= '1;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            value_q   <= value_d;
            enable_q  <= enable_d;
            bright_q  <= bright_d;
            blank_q   <= blank_d;
            blink_q   <= blink_d;
            rawen_q   <= rawen_d;
            raw_q     <= raw_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_d;
            seg_n_q   <= seg_n_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign seg_n                 = seg_n_q;
    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rvalid_q;
    assign w_unused_wdata        = ^avs.avs_writedata;
endmodule
`default_nettype wire

// File: tb/tb_avmm_seven_segment_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_avmm_seven_segment_array
// Brief    : Scoreboard bench for avmm_seven_segment_array (6 digits, fast blink).
// Revision : 1.0
// ============================================================================
module tb_avmm_seven_segment_array;
    localparam int N = 6;

    logic clk = 1'b0;
    logic reset;
    logic [7*N-1:0] seg_n;
    avmm_seven_segment_array_if bus();

    avmm_seven_segment_array #(.NUM_DIGITS(N), .BLINK_DIV(4), .PWM_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .avs   (bus),
        .seg_n (seg_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [31:0] rd_q[$];

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [4*N-1:0]    sh_value;
    logic [N-1:0]      sh_rawen, sh_blank;
    logic [6:0]        sh_raw [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Static display model: enabled, full brightness, no blinking.
    function automatic logic [7*N-1:0] exp_seg();
        logic [7*N-1:0] s;
        logic [6:0] pat;
        for (int d = 0; d < N; d++) begin
            pat = sh_rawen[d] ? sh_raw[d] : HEX[sh_value[4*d +: 4]];
            s[7*d +: 7] = sh_blank[d] ? 7'h7F : (~pat & 7'h7F);
        end
        return s;
    endfunction

    task automatic shadow_reset();
        sh_value = '0; sh_rawen = '0; sh_blank = '0;
        for (int d = 0; d < N; d++) sh_raw[d] = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] data);
        bus.avs_address = a; bus.avs_writedata = data; bus.avs_write = 1'b1;
        tick(1);
        bus.avs_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        bus.avs_address = a; bus.avs_read = 1'b1;
        rd_q.push_back(exp);
        tick(1);
        bus.avs_read = 1'b0;
    endtask

    // Response monitor: readdatavalid must follow an accepted read by exactly one edge.
    always begin
        logic rd_at_edge;
        logic [31:0] e;
        @(posedge clk);
        rd_at_edge = bus.avs_read && !reset;
        #1;
        check("rvalid", bus.avs_readdatavalid, rd_at_edge);
        if (bus.avs_readdatavalid) begin
            if (rd_q.size() == 0) check("spurious_rvalid", 1, 0);
            else begin
                e = rd_q.pop_front();
                check("rdata", bus.avs_readdata, e);
            end
        end
    end

    initial begin
        int lit;
        reset = 1'b1;
        bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
        shadow_reset();
        #2;
        check("rst_seg_ones", seg_n, {7*N{1'b1}});
        check("rst_rvalid", bus.avs_readdatavalid, 0);
        check("rst_rdata", bus.avs_readdata, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        tick(2);
        check("post_rst_zeros", seg_n, {N{7'h40}});
        rd(4'd1, 32'h0000_0F01);
        wr(4'd3, 32'h0);
        rd(4'd5, 32'h0000_0600);

        // Hex decode of A..F
        wr(4'd0, 32'h00FE_DCBA); sh_value = 24'hFEDCBA;
        tick(1);
        check("hex_af", seg_n, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08});
        check("hex_af_model", seg_n, exp_seg());
        rd(4'd0, 32'h00FE_DCBA);

        // Raw override and blanking
        wr(4'd4, 32'h1);  sh_rawen = 6'h01;
        wr(4'd8, 32'h49); sh_raw[0] = 7'h49;
        tick(1);
        check("raw_digit0", seg_n[6:0], 7'h36);
        wr(4'd2, 32'h2);  sh_blank = 6'h02;
        tick(1);
        check("blank_digit1", seg_n[13:7], 7'h7F);
        check("blank_all", seg_n, exp_seg());
        rd(4'd8, 32'h49);
        rd(4'd14, 32'h0);
        wr(4'd2, 32'h0);  sh_blank = '0;

        // Blink: 4 cycles on, 4 off, starting from the BLINK write
        wr(4'd3, 32'h1);
        for (int i = 1; i <= 14; i++) begin
            tick(1);
            check("blink_d0", seg_n[6:0], (((i - 1) / 4) % 2 == 0) ? 7'h36 : 7'h7F);
        end
        check("blink_d1_steady", seg_n[13:7], 7'h03);
        wr(4'd3, 32'h1);
        tick(1);
        check("blink_rewrite_on", seg_n[6:0], 7'h36);
        wr(4'd3, 32'h0);

        // PWM dimming
        wr(4'd1, 32'h0000_0401);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (seg_n[13:7] != 7'h7F) lit++;
        end
        check("pwm_4_of_16", lit, 4);
        wr(4'd1, 32'h0000_0001);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (seg_n != {7*N{1'b1}}) lit++;
        end
        check("pwm_zero_dark", lit, 0);
        wr(4'd1, 32'h0000_0F01);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (seg_n == exp_seg()) lit++;
        end
        check("pwm_full_lit", lit, 16);
        wr(4'd1, 32'h0000_0F00);
        tick(1);
        check("disable_dark", seg_n, {7*N{1'b1}});
        wr(4'd1, 32'h0000_0F01);

        // Simultaneous write and read returns the old value
        bus.avs_address = 4'd0; bus.avs_writedata = 32'h1234_5678;
        bus.avs_write = 1'b1; bus.avs_read = 1'b1;
        rd_q.push_back({8'h0, sh_value});
        tick(1);
        bus.avs_write = 1'b0; bus.avs_read = 1'b0;
        sh_value = 24'h345678;
        rd(4'd0, 32'h0034_5678);
        tick(1);
        check("new_value_seg", seg_n, exp_seg());
        rd(4'd7, 32'h0);
        wr(4'd5, 32'hFFFF_FFFF);
        wr(4'd3, 32'h0);
        rd(4'd5, 32'h0000_0600);

        // Reset during a read: no response survives
        bus.avs_address = 4'd0; bus.avs_read = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("midrd_rvalid", bus.avs_readdatavalid, 0);
        check("midrd_seg", seg_n, {7*N{1'b1}});
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
        check("midrd_rvalid_after", bus.avs_readdatavalid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        shadow_reset();
        tick(2);
        check("rerst_zeros", seg_n, {N{7'h40}});
        rd(4'd0, 32'h0);
        rd(4'd1, 32'h0000_0F01);
        rd(4'd4, 32'h0);
        rd(4'd8, 32'h0);
        tick(3);
        check("pending_reads", rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
